// File: rtl/operand_entry_ctrl.sv
// Front-panel operand entry controller for the signed 8-bit adder.
// Button edge detection, A/B entry with saturating inc/dec and auto-repeat,
// negate, calc sequencing and latching of the adder result for display.
module operand_entry_ctrl #(
  parameter int unsigned HOLD_CYC = 25000000,
  parameter int unsigned RPT_CYC  = 5000000,
  parameter int unsigned ADD_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [7:0] sum_in,
  input  logic       ovf_in,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       sel_b,
  output logic       calc,
  output logic       res_valid,
  output logic [7:0] result,
  output logic       ovf_flag,
  output logic [1:0] state
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LAT_W   = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {
    EDIT_A   = 2'd0,
    EDIT_B   = 2'd1,
    WAIT_ADD = 2'd2,
    SHOW     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       op_a_q, op_a_d;
  logic [7:0]       op_b_q, op_b_d;
  logic             sel_b_q, sel_b_d;
  logic             calc_q, calc_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [3:0] rise;
  logic       editing;
  logic       lat_done;

  assign rise     = btn & ~prev_q;
  assign editing  = (state_q == EDIT_A) || (state_q == EDIT_B);
  assign lat_done = (lat_q == LAT_W'(ADD_LAT - 1));

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EDIT_A;
      prev_q      <= 4'b1111;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      lat_q       <= '0;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      sel_b_q     <= 1'b0;
      calc_q      <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= btn;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      lat_q       <= lat_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sel_b_q     <= sel_b_d;
      calc_q      <= calc_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state: confirm advances the entry sequence, latency counter ends WAIT_ADD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EDIT_A:   if (rise[0]) state_d = EDIT_B;
      EDIT_B:   if (rise[0]) state_d = WAIT_ADD;
      WAIT_ADD: if (lat_done) state_d = SHOW;
      SHOW:     if (rise[0]) state_d = EDIT_A;
      default:  state_d = EDIT_A;
    endcase
  end

  // Outputs: operand editing, auto-repeat timing, calc pulse and result capture
  always_comb begin
    logic       inc_alone;
    logic       dec_alone;
    logic       rpt_fire;
    logic       inc_ev;
    logic       dec_ev;
    logic [7:0] cur;
    logic [7:0] nxt;

    cnt_d       = '0;
    phase_d     = 1'b0;
    lat_d       = '0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sel_b_d     = (state_d == EDIT_B);
    calc_d      = (state_q == EDIT_B) && rise[0];
    res_valid_d = (state_d == SHOW);
    result_d    = result_q;
    ovf_d       = ovf_q;
    rpt_fire    = 1'b0;
    inc_alone   = btn[1] & ~btn[2];
    dec_alone   = btn[2] & ~btn[1];

    // Repeat counter only runs while one of inc/dec is held alone after its rise;
    // phase 0 waits HOLD_CYC from the rise, phase 1 steps every RPT_CYC.
    if (editing && !rise[0] && (inc_alone || dec_alone)) begin
      if ((inc_alone && rise[1]) || (dec_alone && rise[2])) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '0) begin
        if ((!phase_q && cnt_q == CNT_W'(HOLD_CYC)) ||
            (phase_q && cnt_q == CNT_W'(RPT_CYC))) begin
          rpt_fire = 1'b1;
          cnt_d    = CNT_W'(1);
          phase_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = phase_q;
        end
      end
    end

    inc_ev = rise[1] | (rpt_fire & btn[1]);
    dec_ev = rise[2] | (rpt_fire & btn[2]);

    // One edit action per cycle: confirm > negate > inc/dec
    cur = (state_q == EDIT_B) ? op_b_q : op_a_q;
    nxt = cur;
    if (rise[0]) begin
      nxt = cur;
    end else if (rise[3]) begin
      nxt = (cur == 8'h80) ? 8'h7F : 8'(~cur + 8'd1);
    end else if (inc_ev && !dec_ev) begin
      nxt = (cur == 8'h7F) ? cur : 8'(cur + 8'd1);
    end else if (dec_ev && !inc_ev) begin
      nxt = (cur == 8'h80) ? cur : 8'(cur - 8'd1);
    end

    if (state_q == EDIT_A) op_a_d = nxt;
    if (state_q == EDIT_B) op_b_d = nxt;

    if (state_q == WAIT_ADD) begin
      if (lat_done) begin
        result_d = sum_in;
        ovf_d    = ovf_in;
      end else begin
        lat_d = lat_q + LAT_W'(1);
      end
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign sel_b     = sel_b_q;
  assign calc      = calc_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign ovf_flag  = ovf_q;
  assign state     = state_q;

endmodule
